// File: rtl/coinc_gate_counter.sv
// Gated two-channel coincidence counter: counts x2 singles (A), x1 singles (B) and x1/x2 coincidences (C)
// over a gate of GATE enabled cycles. Define SATURATE_EN to make the counters stick at all-ones instead of wrapping.
module coinc_gate_counter #(
  parameter int CW   = 16,
  parameter int WIN  = 4,
  parameter int GATE = 1000
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          enable,
  input  logic          start,
  input  logic          ack,
  input  logic          x1,
  input  logic          x2,
  output logic          busy,
  output logic          valid,
  output logic [CW-1:0] a_cnt,
  output logic [CW-1:0] b_cnt,
  output logic [CW-1:0] c_cnt
);

  localparam int GW = $clog2(GATE + 1);
  localparam int WW = $clog2(WIN + 1);
  localparam logic [GW-1:0] GATE_LAST = GW'(GATE - 1);
  localparam logic [WW-1:0] WIN_LOAD  = WW'(WIN);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t        state, state_nxt;
  logic [GW-1:0] gate, gate_nxt;
  logic [WW-1:0] w1, w1_nxt, w2, w2_nxt;
  logic [CW-1:0] cnt_a, cnt_a_nxt, cnt_b, cnt_b_nxt, cnt_c, cnt_c_nxt;
  logic          load_out;
  logic          coinc;
  logic          w1_open, w2_open;

  // [0],[1] synchroniser, [2] delay flop for rising-edge detection
  logic [2:0] sync1, sync2;
  logic       e1, e2;

  always_ff @(posedge clk) begin
    // NOTE: every flop is assigned with <= so all registers update from the same pre-edge values.
    if (reset) begin
      sync1 <= '0;
      sync2 <= '0;
    end else begin
      sync1 <= {sync1[1:0], x1};
      sync2 <= {sync2[1:0], x2};
    end
  end

  assign e1 = sync1[1] & ~sync1[2];
  assign e2 = sync2[1] & ~sync2[2];

  assign w1_open = (w1 != '0);
  assign w2_open = (w2 != '0);

  function automatic logic [CW-1:0] bump(input logic [CW-1:0] v, input logic inc);
`ifdef SATURATE_EN
    return (inc && (v != {CW{1'b1}})) ? v + CW'(1) : v;
`else
    return v + CW'(inc);
`endif
  endfunction

  always_comb begin
    // NOTE: every output of this block gets a default first, so no path can infer a latch.
    state_nxt = state;
    gate_nxt  = gate;
    w1_nxt    = w1;
    w2_nxt    = w2;
    cnt_a_nxt = cnt_a;
    cnt_b_nxt = cnt_b;
    cnt_c_nxt = cnt_c;
    load_out  = 1'b0;
    coinc     = 1'b0;

    case (state)
      IDLE: begin
        if (start) begin
          state_nxt = RUN;
          gate_nxt  = GATE_LAST;
          w1_nxt    = '0;
          w2_nxt    = '0;
          cnt_a_nxt = '0;
          cnt_b_nxt = '0;
          cnt_c_nxt = '0;
        end
      end
      RUN: begin
        if (enable) begin
          coinc     = (e1 & e2) | (e2 & w1_open) | (e1 & w2_open);
          cnt_a_nxt = bump(cnt_a, e2);
          cnt_b_nxt = bump(cnt_b, e1);
          cnt_c_nxt = bump(cnt_c, coinc);
          // A counted coincidence consumes both opening events
          if (coinc) begin
            w1_nxt = '0;
            w2_nxt = '0;
          end else begin
            w1_nxt = e1 ? WIN_LOAD : (w1_open ? w1 - WW'(1) : w1);
            w2_nxt = e2 ? WIN_LOAD : (w2_open ? w2 - WW'(1) : w2);
          end
          if (gate == '0) begin
            state_nxt = DONE;
            load_out  = 1'b1;
          end else begin
            gate_nxt = gate - GW'(1);
          end
        end
      end
      DONE: begin
        if (ack) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      gate  <= '0;
      w1    <= '0;
      w2    <= '0;
      cnt_a <= '0;
      cnt_b <= '0;
      cnt_c <= '0;
    end else begin
      state <= state_nxt;
      gate  <= gate_nxt;
      w1    <= w1_nxt;
      w2    <= w2_nxt;
      cnt_a <= cnt_a_nxt;
      cnt_b <= cnt_b_nxt;
      cnt_c <= cnt_c_nxt;
    end
  end

  // Results latch the next-state counts so the final gate cycle's events are included
  always_ff @(posedge clk) begin
    if (reset) begin
      a_cnt <= '0;
      b_cnt <= '0;
      c_cnt <= '0;
    end else if (load_out) begin
      a_cnt <= cnt_a_nxt;
      b_cnt <= cnt_b_nxt;
      c_cnt <= cnt_c_nxt;
    end
  end

  assign busy  = (state == RUN);
  assign valid = (state == DONE);

endmodule
